// File: rtl/universal_shiftreg_if.sv
// Bundles the control, data and status signals of the universal shift register.
// The master side drives the operation and data; the slave side reports the register state.
// clk and rst are kept outside the interface as plain ports.
interface universal_shiftreg_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    // Operation request
    logic             en;
    logic [2:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;

    // Register state
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic [CW-1:0]    cnt;
    logic             done;

    modport master (
        output en, mode, sin_r, sin_l, pin,
        input  q, sout_r, sout_l, cnt, done
    );

    modport slave (
        input  en, mode, sin_r, sin_l, pin,
        output q, sout_r, sout_l, cnt, done
    );
endinterface

// File: rtl/universal_shiftreg.sv
// Universal shift register: hold, shift, load, rotate, arithmetic shift and clear, plus a saturating shift counter.
// Latency: every q/cnt/done change is visible one clk edge after the sampled inputs, no pipeline stages.
// No backpressure: an enabled operation is accepted on every edge; en=0 freezes all state.
module universal_shiftreg #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    universal_shiftreg_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_SHR   = 3'b001,
        M_SHL   = 3'b010,
        M_LOAD  = 3'b011,
        M_ROR   = 3'b100,
        M_ROL   = 3'b101,
        M_ASR   = 3'b110,
        M_CLEAR = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_r;
    logic [CW-1:0]    cnt_r;
    logic             done_r;

    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             is_shift;
    logic             is_restart;

    // Next register value and counter action for the selected mode; anything unrecognised holds.
    always_comb begin
        q_nxt      = q_r;
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (mode_e'(bus.mode))
            M_SHR: begin
                q_nxt    = {bus.sin_r, q_r[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_SHL: begin
                q_nxt    = {q_r[WIDTH-2:0], bus.sin_l};
                is_shift = 1'b1;
            end
            M_LOAD: begin
                q_nxt      = bus.pin;
                is_restart = 1'b1;
            end
            M_ROR: begin
                q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_ROL: begin
                q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                is_shift = 1'b1;
            end
            M_ASR: begin
                q_nxt    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                is_shift = 1'b1;
            end
            M_CLEAR: begin
                q_nxt      = '0;
                is_restart = 1'b1;
            end
            default: begin
                q_nxt = q_r;
            end
        endcase
    end

    // Shift counter: restarts on load/clear, counts shifts and rotates, saturates at WIDTH.
    always_comb begin
        cnt_nxt = cnt_r;
        if (is_restart) begin
            cnt_nxt = '0;
        end else if (is_shift && (cnt_r != CNT_MAX)) begin
            cnt_nxt = cnt_r + CW'(1);
        end
    end

    // State update; done is registered from the same next-count so it rises together with cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            cnt_r  <= '0;
            done_r <= 1'b0;
        end else if (bus.en) begin
            q_r    <= q_nxt;
            cnt_r  <= cnt_nxt;
            done_r <= (cnt_nxt == CNT_MAX);
        end
    end

    assign bus.q      = q_r;
    assign bus.cnt    = cnt_r;
    assign bus.done   = done_r;
    // Serial outs are forced low directly by rst, independent of the register clear.
    assign bus.sout_r = rst ? 1'b0 : q_r[0];
    assign bus.sout_l = rst ? 1'b0 : q_r[WIDTH-1];
endmodule

// File: tb/tb_universal_shiftreg.sv
// Directed bench for universal_shiftreg (WIDTH=8): table of hand-computed vectors plus reset sequences.
module tb_universal_shiftreg;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    universal_shiftreg_if #(.WIDTH(8)) bus ();

    universal_shiftreg #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic       sr;
        logic       sl;
        logic [7:0] pin;
        logic [7:0] q;
        logic [3:0] cnt;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, input logic [2:0] mode, input logic sr, input logic sl,
                       input logic [7:0] pin, input logic [7:0] q, input logic [3:0] cnt,
                       input logic done);
        vec_t v;
        v.en = en; v.mode = mode; v.sr = sr; v.sl = sl; v.pin = pin;
        v.q = q; v.cnt = cnt; v.done = done;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [7:0] q, input logic [3:0] cnt,
                             input logic done);
        logic [7:0] eq;
        eq = q;
        check({name, " q"},      32'(bus.q),      32'(eq));
        check({name, " cnt"},    32'(bus.cnt),    32'(cnt));
        check({name, " done"},   32'(bus.done),   32'(done));
        check({name, " sout_r"}, 32'(bus.sout_r), rst ? 32'd0 : 32'(eq[0]));
        check({name, " sout_l"}, 32'(bus.sout_l), rst ? 32'd0 : 32'(eq[7]));
    endtask

    task automatic drive(input logic en, input logic [2:0] mode, input logic sr, input logic sl,
                         input logic [7:0] pin);
        bus.en = en; bus.mode = mode; bus.sin_r = sr; bus.sin_l = sl; bus.pin = pin;
    endtask

    initial begin
        // Load 10110011 then shift right out: sout_r walks 1,1,0,0,1,1,0,1
        add(1, 3'b011, 0, 0, 8'hB3, 8'hB3, 0, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h59, 1, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h2C, 2, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h16, 3, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h0B, 4, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h05, 5, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h02, 6, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h01, 7, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h00, 8, 1);
        add(1, 3'b001, 1, 0, 8'h00, 8'h80, 8, 1);   // 9th shift: q moves, cnt saturated
        add(0, 3'b111, 0, 0, 8'h00, 8'h80, 8, 1);   // disabled clear holds everything
        add(0, 3'b011, 0, 0, 8'hFF, 8'h80, 8, 1);   // disabled load holds everything
        // Shift left, then 8 lossless rotates right
        add(1, 3'b011, 0, 0, 8'h81, 8'h81, 0, 0);
        add(1, 3'b010, 0, 1, 8'h00, 8'h03, 1, 0);
        add(1, 3'b100, 0, 0, 8'h00, 8'h81, 2, 0);
        add(1, 3'b100, 0, 0, 8'h00, 8'hC0, 3, 0);
        add(1, 3'b100, 0, 0, 8'h00, 8'h60, 4, 0);
        add(1, 3'b100, 0, 0, 8'h00, 8'h30, 5, 0);
        add(1, 3'b100, 0, 0, 8'h00, 8'h18, 6, 0);
        add(1, 3'b100, 0, 0, 8'h00, 8'h0C, 7, 0);
        add(1, 3'b100, 0, 0, 8'h00, 8'h06, 8, 1);
        add(1, 3'b100, 0, 0, 8'h00, 8'h03, 8, 1);
        add(1, 3'b101, 0, 0, 8'h00, 8'h06, 8, 1);
        add(1, 3'b101, 0, 0, 8'h00, 8'h0C, 8, 1);
        // Arithmetic shift right, negative then positive
        add(1, 3'b011, 0, 0, 8'h90, 8'h90, 0, 0);
        add(1, 3'b110, 0, 0, 8'h00, 8'hC8, 1, 0);
        add(1, 3'b110, 0, 0, 8'h00, 8'hE4, 2, 0);
        add(1, 3'b110, 0, 0, 8'h00, 8'hF2, 3, 0);
        add(1, 3'b011, 0, 0, 8'h40, 8'h40, 0, 0);
        add(1, 3'b110, 0, 0, 8'h00, 8'h20, 1, 0);
        add(1, 3'b000, 1, 1, 8'hFF, 8'h20, 1, 0);   // enabled hold
        // Enable gating, direction reversal and clear
        add(1, 3'b011, 0, 0, 8'hCC, 8'hCC, 0, 0);
        add(0, 3'b001, 1, 0, 8'h00, 8'hCC, 0, 0);
        add(0, 3'b001, 1, 0, 8'h00, 8'hCC, 0, 0);
        add(0, 3'b001, 1, 0, 8'h00, 8'hCC, 0, 0);
        add(0, 3'b001, 1, 0, 8'h00, 8'hCC, 0, 0);
        add(1, 3'b001, 1, 0, 8'h00, 8'hE6, 1, 0);
        add(0, 3'b111, 0, 0, 8'h00, 8'hE6, 1, 0);
        add(1, 3'b010, 0, 0, 8'h00, 8'hCC, 2, 0);
        add(1, 3'b001, 0, 0, 8'h00, 8'h66, 3, 0);
        add(1, 3'b111, 0, 0, 8'h00, 8'h00, 0, 0);

        // Reset state visible before any clock edge
        rst = 1'b1;
        drive(1, 3'b011, 0, 0, 8'hA5);
        #1;
        check_all("reset_pre_edge", 8'h00, 0, 0);
        // Edges under reset do nothing
        @(posedge clk); @(posedge clk); #1;
        check_all("reset_edges_ignored", 8'h00, 0, 0);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        check_all("first_edge_after_reset", 8'hA5, 0, 0);
        // Asynchronous reset with nonzero contents, cleared between edges
        #3 rst = 1'b1;
        #1;
        check_all("async_reset_loaded", 8'h00, 0, 0);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].mode, vecs[i].sr, vecs[i].sl, vecs[i].pin);
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].cnt, vecs[i].done);
        end

        // Reset mid-shift discards progress; next shift starts fresh
        drive(1, 3'b011, 0, 0, 8'h5A);
        @(posedge clk); #1;
        check_all("mid_load", 8'h5A, 0, 0);
        drive(1, 3'b001, 0, 0, 8'h00);
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check_all("mid_three_shifts", 8'h0B, 3, 0);
        #3 rst = 1'b1;
        #1;
        check_all("mid_async_reset", 8'h00, 0, 0);
        #2 rst = 1'b0;
        drive(1, 3'b010, 0, 1, 8'h00);
        @(posedge clk); #1;
        check_all("mid_after_release", 8'h01, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/universal_shiftreg.md
UNIVERSAL_SHIFTREG -- requirements
Module: universal_shiftreg

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 The block SHALL have a derived localparam: CW, default $clog2(WIDTH+1), counter width.
REQ-003 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  Asynchronous, active-high reset.
REQ-005 en  input  1  Operation enable; when 0 all state holds.
REQ-006 mode  input  3  Operation select, per REQ-011.
REQ-007 sin_r  input  1  Serial in for right shift, enters q[WIDTH-1].
REQ-008 sin_l  input  1  Serial in for left shift, enters q[0].
REQ-009 pin  input  WIDTH  Parallel load data.
REQ-010 The outputs SHALL be:
- q  output  WIDTH  Register contents.
- sout_r  output  1  Right-shift serial out.
- sout_l  output  1  Left-shift serial out.
- cnt  output  CW  Shifts since last load/clear.
- done  output  1  cnt has reached WIDTH.

Function
REQ-011 With en=1, on the rising clk edge, q SHALL update per mode:
- 000 hold: no change.
- 001 shift right: q <= {sin_r, q[W-1:1]}.
- 010 shift left: q <= {q[W-2:0], sin_l}.
- 011 parallel load: q <= pin.
- 100 rotate right: q <= {q[0], q[W-1:1]}.
- 101 rotate left: q <= {q[W-2:0], q[W-1]}.
- 110 arithmetic shift right: q <= {q[W-1], q[W-1:1]}.
- 111 synchronous clear: q <= 0.
REQ-012 With en=0, q, cnt and done SHALL hold regardless of mode or serial inputs.
REQ-013 sout_r SHALL be combinational: 0 while rst=1, else q[0].
REQ-014 sout_l SHALL be combinational: 0 while rst=1, else q[WIDTH-1].
REQ-015 cnt SHALL be set to 0 on an enabled load (011) or clear (111).
REQ-016 cnt SHALL increment by 1 on every enabled shift or rotate (modes 001, 010, 100, 101, 110).
REQ-017 cnt SHALL saturate at WIDTH; further shifts leave it at WIDTH while q keeps shifting.
REQ-018 cnt SHALL be unchanged in hold (000).
REQ-019 done SHALL be registered and equal (cnt == WIDTH), updated in the same edge as cnt, so it asserts coincident with cnt reaching WIDTH.
REQ-020 Latency: every q/cnt/done change SHALL be visible one clk edge after the sampled inputs, with no pipeline stages.
REQ-021 Mode changes SHALL take effect at the next edge with no turnaround cycle; the direction may reverse on consecutive edges.
REQ-022 Rotations SHALL be lossless; WIDTH consecutive rotates in one direction SHALL return q to its original value.
REQ-023 Unknown or X mode values SHALL be treated as hold in simulation; X SHALL NOT propagate into q.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force q=0, cnt=0, done=0, sout_r=0 and sout_l=0.
REQ-025 rst asserted mid-sequence (e.g. cnt=3) SHALL discard all progress; no partial state survives.
REQ-026 While rst=1, clk edges SHALL have no effect; the first rising edge after rst falls SHALL perform the selected operation normally.

Verification (WIDTH=8)
REQ-027 Reset: rst=1 with random q, then release -> q=00000000, cnt=0, done=0, sout_r=0, sout_l=0; outputs clear before any clk edge.
REQ-028 Load then shift right: load pin=10110011, then 8 shifts right with sin_r=0 -> sout_r sequence 1,1,0,0,1,1,0,1; q=00000000; cnt=8; done=1 on the 8th edge; a 9th shift keeps cnt=8.
REQ-029 Shift left and rotate: load 10000001, shift left once with sin_l=1 -> q=00000011; rotate right 8 times -> q=00000011; cnt=8.
REQ-030 Arithmetic shift right: load 10010000, ASR 3 times -> q=11110010; load 01000000, ASR once -> q=00100000.
REQ-031 Enable gating and clear: load 11001100, en=0 with mode=001 for 4 edges -> q and cnt unchanged; en=1 mode=111 -> q=0, cnt=0, done=0.
REQ-032 Asynchronous reset mid-shift: after 3 shifts, assert rst between edges -> q=0 and cnt=0 immediately; release; the first shift left with sin_l=1 -> q=00000001, cnt=1.
